// File: rtl/rpm_gauge_core.sv
// rtl/rpm_gauge_core.sv - gear-limited speed level with coast-down, overrev flag, stage LED and bargraph
module rpm_gauge_core #(
  parameter int LEVEL_W        = 4,
  parameter int MAX_LEVEL      = 15,
  parameter int GEAR_STEP      = 3,
  parameter int NUM_GEARS      = 6,
  parameter int BAR_SEGS       = 5,
  parameter int COAST_CYCLES   = 1000,
  parameter int BLINK_CYCLES   = 250,
  parameter int OVERREV_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accel_pulse,
  input  logic                decel_pulse,
  input  logic [2:0]          gear,
  output logic [LEVEL_W-1:0]  speed_level,
  output logic [LEVEL_W-1:0]  max_level,
  output logic [1:0]          stage,
  output logic [2:0]          rgb,
  output logic [BAR_SEGS-1:0] bar,
  output logic                overrev
);

  localparam int CW = (COAST_CYCLES > 1) ? $clog2(COAST_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int OW = (OVERREV_CYCLES > 0) ? $clog2(OVERREV_CYCLES + 1) : 1;
  localparam int PW = LEVEL_W + 4;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_CAUTION = 2'd1,
    ST_DANGER  = 2'd2
  } stage_e;

  logic [LEVEL_W-1:0]  speed_q, speed_d;
  logic [CW-1:0]       coast_q, coast_d;
  logic [OW-1:0]       ovr_q, ovr_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic                blink_off_q, blink_off_d;
  stage_e              stage_q, stage_d;
  logic [2:0]          rgb_q, rgb_d;
  logic [BAR_SEGS-1:0] bar_q, bar_d;

  logic [31:0]         gear_prod;
  logic                clamp;
  logic [LEVEL_W-1:0]  half_max;

  always_comb begin
    gear_prod = 32'(gear) * 32'(GEAR_STEP);
    if (gear == 3'd0 || 32'(gear) >= 32'(NUM_GEARS)) begin
      max_level = '0;
    end else if (gear_prod > 32'(MAX_LEVEL)) begin
      max_level = LEVEL_W'(MAX_LEVEL);
    end else begin
      max_level = gear_prod[LEVEL_W-1:0];
    end
  end

  // Clamp wins over pulses, and pulses win over coasting.
  always_comb begin
    speed_d = speed_q;
    coast_d = coast_q;
    ovr_d   = (ovr_q != '0) ? ovr_q - 1'b1 : ovr_q;
    clamp   = speed_q > max_level;
    if (clamp) begin
      speed_d = max_level;
      coast_d = '0;
      ovr_d   = OW'(OVERREV_CYCLES);
    end else if (accel_pulse && !decel_pulse) begin
      coast_d = '0;
      if (speed_q < max_level) speed_d = speed_q + 1'b1;
    end else if (decel_pulse && !accel_pulse) begin
      coast_d = '0;
      if (speed_q != '0) speed_d = speed_q - 1'b1;
    end else if (accel_pulse && decel_pulse) begin
      coast_d = '0;
    end else if (speed_q == '0 || COAST_CYCLES == 0) begin
      coast_d = '0;
    end else if (coast_q == CW'(COAST_CYCLES - 1)) begin
      speed_d = speed_q - 1'b1;
      coast_d = '0;
    end else begin
      coast_d = coast_q + 1'b1;
    end
  end

  always_comb begin
    half_max = max_level >> 1;
    if (max_level == '0) begin
      stage_d = ST_NORMAL;
    end else if (speed_q >= max_level) begin
      stage_d = ST_DANGER;
    end else if (speed_q >= half_max) begin
      stage_d = ST_CAUTION;
    end else begin
      stage_d = ST_NORMAL;
    end
  end

  // Blink phase restarts "on" whenever danger is freshly entered.
  always_comb begin
    blink_d     = '0;
    blink_off_d = 1'b0;
    if (stage_d == ST_DANGER && stage_q == ST_DANGER) begin
      blink_d     = blink_q;
      blink_off_d = blink_off_q;
      if (BLINK_CYCLES != 0) begin
        if (blink_q == BW'(BLINK_CYCLES - 1)) begin
          blink_d     = '0;
          blink_off_d = ~blink_off_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (stage_d)
      ST_CAUTION: rgb_d = 3'b110;
      ST_DANGER:  rgb_d = blink_off_d ? 3'b000 : 3'b100;
      default:    rgb_d = 3'b010;
    endcase
  end

  always_comb begin
    bar_d = '0;
    if (max_level != '0) begin
      bar_d[0] = speed_q != '0;
      for (int i = 1; i < BAR_SEGS; i++) begin
        bar_d[i] = (PW'(speed_q) * PW'(BAR_SEGS)) >= (PW'(i) * PW'(max_level));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q     <= '0;
      coast_q     <= '0;
      ovr_q       <= '0;
      blink_q     <= '0;
      blink_off_q <= 1'b0;
      stage_q     <= ST_NORMAL;
      rgb_q       <= 3'b010;
      bar_q       <= '0;
    end else begin
      speed_q     <= speed_d;
      coast_q     <= coast_d;
      ovr_q       <= ovr_d;
      blink_q     <= blink_d;
      blink_off_q <= blink_off_d;
      stage_q     <= stage_d;
      rgb_q       <= rgb_d;
      bar_q       <= bar_d;
    end
  end

  assign speed_level = speed_q;
  assign stage       = stage_q;
  assign rgb         = rgb_q;
  assign bar         = bar_q;
  assign overrev     = ovr_q != '0;

endmodule

// File: tb/tb_rpm_gauge_core.sv
// tb/tb_rpm_gauge_core.sv - directed and randomized checks of rpm_gauge_core against an integer model
module tb_rpm_gauge_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       accel_pulse = 1'b0;
  logic       decel_pulse = 1'b0;
  logic [2:0] gear = 3'd0;
  logic [3:0] speed_level;
  logic [3:0] max_level;
  logic [1:0] stage;
  logic [2:0] rgb;
  logic [4:0] bar;
  logic       overrev;

  int checks = 0;
  int failures = 0;

  rpm_gauge_core dut (
    .clk(clk), .rst(rst), .accel_pulse(accel_pulse), .decel_pulse(decel_pulse),
    .gear(gear), .speed_level(speed_level), .max_level(max_level), .stage(stage),
    .rgb(rgb), .bar(bar), .overrev(overrev)
  );

  always #5 clk = ~clk;

  // Reference model: integer arithmetic straight from the level, stage and bar rules.
  function automatic int ceiling_of(int g);
    if (g == 0 || g >= 6) return 0;
    return (g * 3 > 15) ? 15 : g * 3;
  endfunction

  int m_speed, m_idle, m_since, m_stage, m_age;
  logic [2:0] m_rgb;
  logic [4:0] m_bar;
  int e_mx, n_speed, n_idle, n_since, n_stage, n_age;
  logic [2:0] n_rgb;
  logic [4:0] n_bar;

  always @* begin
    e_mx    = ceiling_of(int'(gear));
    n_speed = m_speed;
    n_idle  = m_idle;
    n_since = (m_since >= 500) ? 500 : m_since + 1;
    if (m_speed > e_mx) begin
      n_speed = e_mx;
      n_idle  = 0;
      n_since = 0;
    end else begin
      n_speed = m_speed + int'(accel_pulse) - int'(decel_pulse);
      if (n_speed < 0) n_speed = 0;
      if (n_speed > e_mx) n_speed = e_mx;
      if (accel_pulse || decel_pulse || m_speed == 0) n_idle = 0;
      else if (m_idle + 1 == 1000) begin
        n_speed = m_speed - 1;
        n_idle  = 0;
      end else n_idle = m_idle + 1;
    end
    if (e_mx == 0) n_stage = 0;
    else if (m_speed >= e_mx) n_stage = 2;
    else if (m_speed >= e_mx / 2) n_stage = 1;
    else n_stage = 0;
    n_age = (n_stage == 2 && m_stage == 2) ? m_age + 1 : 0;
    if (n_stage == 0) n_rgb = 3'b010;
    else if (n_stage == 1) n_rgb = 3'b110;
    else n_rgb = (((n_age / 250) % 2) == 0) ? 3'b100 : 3'b000;
    n_bar = '0;
    if (e_mx != 0) begin
      for (int i = 0; i < 5; i++) begin
        n_bar[i] = (i == 0) ? (m_speed > 0) : (m_speed * 5 >= i * e_mx);
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_speed <= 0; m_idle <= 0; m_since <= 500; m_stage <= 0; m_age <= 0;
      m_rgb <= 3'b010; m_bar <= '0;
    end else begin
      m_speed <= n_speed; m_idle <= n_idle; m_since <= n_since; m_stage <= n_stage;
      m_age <= n_age; m_rgb <= n_rgb; m_bar <= n_bar;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    accel_pulse = 1'b0;
    decel_pulse = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic accel_n(int n);
    accel_pulse = 1'b1;
    repeat (n) tick();
    accel_pulse = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    gear = 3'd5;
    accel_n(5);
    rst = 1'b1;
    #1;
    checks += 5;
    if (speed_level !== 4'd0) begin failures++; $display("FAIL reset_speed got=%0d exp=0", speed_level); end
    if (stage !== 2'd0) begin failures++; $display("FAIL reset_stage got=%0d exp=0", stage); end
    if (rgb !== 3'b010) begin failures++; $display("FAIL reset_rgb got=%b exp=010", rgb); end
    if (bar !== 5'b0) begin failures++; $display("FAIL reset_bar got=%b exp=00000", bar); end
    if (overrev !== 1'b0) begin failures++; $display("FAIL reset_overrev got=%b exp=0", overrev); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks += 3;
    if (speed_level !== 4'd0) begin failures++; $display("FAIL post_reset_speed got=%0d exp=0", speed_level); end
    if (overrev !== 1'b0) begin failures++; $display("FAIL post_reset_overrev got=%b exp=0", overrev); end
    if (max_level !== 4'd15) begin failures++; $display("FAIL max_gear5 got=%0d exp=15", max_level); end
  endtask

  task automatic test_saturate();
    int on_cnt, off_cnt;
    do_reset();
    gear = 3'd5;
    accel_n(16);
    checks += 4;
    if (speed_level !== 4'd15) begin failures++; $display("FAIL sat_speed got=%0d exp=15", speed_level); end
    if (stage !== 2'd2) begin failures++; $display("FAIL sat_stage got=%0d exp=2", stage); end
    if (bar !== 5'b11111) begin failures++; $display("FAIL sat_bar got=%b exp=11111", bar); end
    if (rgb !== 3'b100) begin failures++; $display("FAIL blink_entry got=%b exp=100", rgb); end
    on_cnt = 1;
    while (rgb === 3'b100 && on_cnt < 600) begin tick(); if (rgb === 3'b100) on_cnt++; end
    off_cnt = 0;
    while (rgb === 3'b000 && off_cnt < 600) begin tick(); off_cnt++; end
    checks += 3;
    if (on_cnt !== 250) begin failures++; $display("FAIL blink_on_len got=%0d exp=250", on_cnt); end
    if (off_cnt !== 250) begin failures++; $display("FAIL blink_off_len got=%0d exp=250", off_cnt); end
    if (rgb !== 3'b100) begin failures++; $display("FAIL blink_reon got=%b exp=100", rgb); end
  endtask

  task automatic test_downshift();
    int ov_cnt;
    do_reset();
    gear = 3'd5;
    accel_n(12);
    gear = 3'd2;
    decel_pulse = 1'b1;
    tick();
    decel_pulse = 1'b0;
    checks += 3;
    if (speed_level !== 4'd6) begin failures++; $display("FAIL clamp_speed got=%0d exp=6", speed_level); end
    if (overrev !== 1'b1) begin failures++; $display("FAIL clamp_overrev got=%b exp=1", overrev); end
    if (max_level !== 4'd6) begin failures++; $display("FAIL clamp_max got=%0d exp=6", max_level); end
    ov_cnt = 1;
    while (overrev === 1'b1 && ov_cnt < 700) begin tick(); if (overrev === 1'b1) ov_cnt++; end
    checks += 2;
    if (ov_cnt !== 500) begin failures++; $display("FAIL overrev_len got=%0d exp=500", ov_cnt); end
    if (speed_level !== 4'd6) begin failures++; $display("FAIL clamp_hold got=%0d exp=6", speed_level); end
  endtask

  task automatic test_coast();
    int exp_s;
    do_reset();
    gear = 3'd2;
    accel_n(3);
    checks++;
    if (speed_level !== 4'd3) begin failures++; $display("FAIL coast_start got=%0d exp=3", speed_level); end
    for (int n = 1; n <= 3200; n++) begin
      tick();
      if (n == 999 || n == 1000 || n == 1999 || n == 2000 || n == 2999 || n == 3000 || n == 3200) begin
        exp_s = 3 - n / 1000;
        if (exp_s < 0) exp_s = 0;
        checks++;
        if (int'(speed_level) !== exp_s) begin
          failures++; $display("FAIL coast_n%0d got=%0d exp=%0d", n, speed_level, exp_s);
        end
      end
    end
  endtask

  task automatic test_both();
    do_reset();
    gear = 3'd2;
    accel_n(4);
    repeat (600) tick();
    checks++;
    if (speed_level !== 4'd4) begin failures++; $display("FAIL both_pre got=%0d exp=4", speed_level); end
    accel_pulse = 1'b1;
    decel_pulse = 1'b1;
    tick();
    accel_pulse = 1'b0;
    decel_pulse = 1'b0;
    checks++;
    if (speed_level !== 4'd4) begin failures++; $display("FAIL both_hold got=%0d exp=4", speed_level); end
    repeat (999) tick();
    checks++;
    if (speed_level !== 4'd4) begin failures++; $display("FAIL both_zeroed got=%0d exp=4", speed_level); end
    tick();
    checks++;
    if (speed_level !== 4'd3) begin failures++; $display("FAIL both_coast got=%0d exp=3", speed_level); end
  endtask

  task automatic test_invalid_gear();
    int glist [3] = '{0, 7, 6};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      gear = 3'(glist[k]);
      accel_n(5);
      tick();
      checks += 4;
      if (max_level !== 4'd0) begin failures++; $display("FAIL inv_max g=%0d got=%0d exp=0", glist[k], max_level); end
      if (speed_level !== 4'd0) begin failures++; $display("FAIL inv_speed g=%0d got=%0d exp=0", glist[k], speed_level); end
      if (bar !== 5'b0) begin failures++; $display("FAIL inv_bar g=%0d got=%b exp=00000", glist[k], bar); end
      if (stage !== 2'd0) begin failures++; $display("FAIL inv_stage g=%0d got=%0d exp=0", glist[k], stage); end
    end
  endtask

  task automatic test_bar_stage();
    do_reset();
    gear = 3'd5;
    accel_n(6);
    tick();
    checks += 4;
    if (speed_level !== 4'd6) begin failures++; $display("FAIL bs_speed6 got=%0d exp=6", speed_level); end
    if (bar !== 5'b00111) begin failures++; $display("FAIL bs_bar6 got=%b exp=00111", bar); end
    if (stage !== 2'd0) begin failures++; $display("FAIL bs_stage6 got=%0d exp=0", stage); end
    if (rgb !== 3'b010) begin failures++; $display("FAIL bs_rgb6 got=%b exp=010", rgb); end
    accel_n(1);
    tick();
    checks += 3;
    if (speed_level !== 4'd7) begin failures++; $display("FAIL bs_speed7 got=%0d exp=7", speed_level); end
    if (stage !== 2'd1) begin failures++; $display("FAIL bs_stage7 got=%0d exp=1", stage); end
    if (rgb !== 3'b110) begin failures++; $display("FAIL bs_rgb7 got=%b exp=110", rgb); end
  endtask

  task automatic test_random();
    int mode, pa, pd;
    do_reset();
    gear = 3'd5;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      mode = (cyc / 1500) % 3;
      pa = (mode == 0) ? 30 : (mode == 1) ? 5 : 0;
      pd = (mode == 0) ? 10 : (mode == 1) ? 5 : 0;
      accel_pulse = $urandom_range(0, 99) < pa;
      decel_pulse = $urandom_range(0, 99) < pd;
      if ($urandom_range(0, 399) == 0) gear = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 4999) == 0);
      tick();
      rst = 1'b0;
      checks += 6;
      if (int'(speed_level) !== m_speed) begin failures++; $display("FAIL rand_speed cyc=%0d got=%0d exp=%0d", cyc, speed_level, m_speed); end
      if (int'(max_level) !== ceiling_of(int'(gear))) begin failures++; $display("FAIL rand_max cyc=%0d got=%0d exp=%0d", cyc, max_level, ceiling_of(int'(gear))); end
      if (int'(stage) !== m_stage) begin failures++; $display("FAIL rand_stage cyc=%0d got=%0d exp=%0d", cyc, stage, m_stage); end
      if (rgb !== m_rgb) begin failures++; $display("FAIL rand_rgb cyc=%0d got=%b exp=%b", cyc, rgb, m_rgb); end
      if (bar !== m_bar) begin failures++; $display("FAIL rand_bar cyc=%0d got=%b exp=%b", cyc, bar, m_bar); end
      if (overrev !== (m_since < 500)) begin failures++; $display("FAIL rand_overrev cyc=%0d got=%b exp=%b", cyc, overrev, (m_since < 500)); end
    end
  endtask

  initial begin
    #2;
    rst = 1'b1;
    #10;
    rst = 1'b0;
    test_reset();
    test_saturate();
    test_downshift();
    test_coast();
    test_both();
    test_invalid_gear();
    test_bar_stage();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
